// File: rtl/send_scheduler.sv
// Frame send scheduler: runs (segment, copy) launches through the packet builder,
// paced by the builder's busy/done handshake and an inter-packet gap.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in progress, waiting for start_frame
// WAIT_BUSY | frame active, waiting for the packet builder to go idle
// LAUNCH    | start_sending strobe cycle for the current (segment, copy)
// WAIT_DONE | waiting for the builder's oneframe_done pulse
// GAP       | inter-packet idle time, then index advance
// FINISH    | all pairs sent; frame_done follows, then back to IDLE
module send_scheduler #(
   parameter int SEG_W   = 16,
   parameter int RED_W   = 3,
   parameter int ID_W    = 8,
   parameter int GAP_CYC = 12
) (
   input  logic             clk125MHz,
   input  logic             RST_N,
   input  logic             start_frame,
   input  logic [SEG_W-1:0] seg_count,
   input  logic [RED_W-1:0] redundancy_cfg,
   input  logic             mode,
   input  logic             busy,
   input  logic             oneframe_done,
   input  logic             abort,
   output logic [SEG_W-1:0] segment_num,
   output logic [ID_W-1:0]  txid,
   output logic [RED_W-1:0] aux,
   output logic             start_sending,
   output logic             frame_busy,
   output logic             frame_done
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_BUSY = 3'd1;
   localparam logic [2:0] S_LAUNCH    = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;
   localparam logic [2:0] S_FINISH    = 3'd5;

   localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
   localparam logic [RED_W-1:0] RED_ONE  = RED_W'(1);
   localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);

   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [SEG_W-1:0] seg_cnt_q;
   logic [RED_W-1:0] red_cnt_q;
   logic             mode_q;
   logic [SEG_W-1:0] seg_idx;
   logic [RED_W-1:0] copy_idx;
   logic [ID_W-1:0]  id_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             seg_last;
   logic             copy_last;
   logic             gap_tc;
   logic             frame_go;

   // Compare against count-1 so an all-ones seg_count never overflows.
   assign seg_last  = (seg_idx == (seg_cnt_q - SEG_ONE));
   assign copy_last = (copy_idx == (red_cnt_q - RED_ONE));
   assign gap_tc    = (gap_cnt <= GAP_ONE);
   assign frame_go  = (state == S_IDLE) && start_frame && !abort;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (frame_go) begin
               state_nx = (seg_count == '0) ? S_FINISH : S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (!busy) begin
               state_nx = S_LAUNCH;
            end
         end
         S_LAUNCH:    state_nx = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (oneframe_done) begin
               state_nx = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_tc) begin
               state_nx = (seg_last && copy_last) ? S_FINISH : S_WAIT_BUSY;
            end
         end
         S_FINISH:    state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) begin
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk125MHz or negedge RST_N) begin
      if (!RST_N) begin
         state         <= S_IDLE;
         seg_cnt_q     <= '0;
         red_cnt_q     <= '0;
         mode_q        <= 1'b0;
         seg_idx       <= '0;
         copy_idx      <= '0;
         id_cnt        <= '0;
         gap_cnt       <= '0;
         segment_num   <= '0;
         txid          <= '0;
         aux           <= '0;
         start_sending <= 1'b0;
         frame_busy    <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         state         <= state_nx;
         start_sending <= (state_nx == S_LAUNCH);
         frame_busy    <= (state_nx != S_IDLE);
         frame_done    <= (state == S_FINISH) && !abort;

         if (frame_go) begin
            seg_cnt_q <= seg_count;
            red_cnt_q <= (redundancy_cfg == '0) ? RED_ONE : redundancy_cfg;
            mode_q    <= mode;
            seg_idx   <= '0;
            copy_idx  <= '0;
         end

         if (state_nx == S_LAUNCH) begin
            segment_num <= seg_idx;
            aux         <= copy_idx;
            txid        <= id_cnt;
         end

         // The ID counter runs ahead of txid so the output holds until the next launch.
         if (state == S_LAUNCH) begin
            id_cnt <= id_cnt + ID_ONE;
         end

         if ((state == S_WAIT_DONE) && oneframe_done && !abort) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state == S_GAP) && !gap_tc && !abort) begin
            gap_cnt <= gap_cnt - GAP_ONE;
         end

         if ((state == S_GAP) && gap_tc && !abort) begin
            if (!mode_q) begin
               if (copy_last) begin
                  copy_idx <= '0;
                  seg_idx  <= seg_idx + SEG_ONE;
               end else begin
                  copy_idx <= copy_idx + RED_ONE;
               end
            end else begin
               if (seg_last) begin
                  seg_idx  <= '0;
                  copy_idx <= copy_idx + RED_ONE;
               end else begin
                  seg_idx  <= seg_idx + SEG_ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_send_scheduler.sv
// Directed bench for send_scheduler with a packet-builder responder that
// answers every launch with oneframe_done four cycles later.
module tb_send_scheduler;

   logic        clk125MHz;
   logic        RST_N;
   logic        start_frame;
   logic [15:0] seg_count;
   logic [2:0]  redundancy_cfg;
   logic        mode;
   logic        busy;
   logic        oneframe_done;
   logic        abort;
   logic [15:0] segment_num;
   logic [7:0]  txid;
   logic [2:0]  aux;
   logic        start_sending;
   logic        frame_busy;
   logic        frame_done;

   send_scheduler #(.SEG_W(16), .RED_W(3), .ID_W(8), .GAP_CYC(12)) dut (
      .clk125MHz      (clk125MHz),
      .RST_N          (RST_N),
      .start_frame    (start_frame),
      .seg_count      (seg_count),
      .redundancy_cfg (redundancy_cfg),
      .mode           (mode),
      .busy           (busy),
      .oneframe_done  (oneframe_done),
      .abort          (abort),
      .segment_num    (segment_num),
      .txid           (txid),
      .aux            (aux),
      .start_sending  (start_sending),
      .frame_busy     (frame_busy),
      .frame_done     (frame_done)
   );

   typedef struct {
      int seg;
      int aux;
      int id;
      int cyc;
   } launch_t;

   launch_t lq[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fd_cnt = 0;
   int fd_cyc = 0;
   int st_cyc = 0;
   int pend   = 0;

   int e_seg_m0[6] = '{0, 0, 1, 1, 2, 2};
   int e_aux_m0[6] = '{0, 1, 0, 1, 0, 1};
   int e_seg_m1[6] = '{0, 1, 2, 0, 1, 2};
   int e_aux_m1[6] = '{0, 0, 0, 1, 1, 1};

   initial clk125MHz = 1'b0;
   always #5 clk125MHz = ~clk125MHz;

   always @(posedge clk125MHz) cyc = cyc + 1;

   always @(negedge clk125MHz) begin
      if (start_sending) lq.push_back(launch_t'{int'(segment_num), int'(aux), int'(txid), cyc});
      if (frame_done) begin
         fd_cnt = fd_cnt + 1;
         fd_cyc = cyc;
      end
   end

   // Packet builder model: oneframe_done pulses in the 4th cycle after the launch.
   initial begin
      oneframe_done = 1'b0;
      forever begin
         @(posedge clk125MHz);
         #1;
         oneframe_done = 1'b0;
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) oneframe_done = 1'b1;
         end
         if (start_sending) pend = 4;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk125MHz);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk125MHz);
      #1;
      RST_N = 1'b0;
      start_frame = 1'b0;
      abort = 1'b0;
      busy = 1'b0;
      tick(2);
      RST_N = 1'b1;
      pend = 0;
      lq.delete();
      fd_cnt = 0;
      tick(1);
   endtask

   task automatic start(input int sc, input int rc, input logic m);
      tick(1);
      seg_count      = 16'(sc);
      redundancy_cfg = 3'(rc);
      mode           = m;
      start_frame    = 1'b1;
      st_cyc         = cyc;
      tick(1);
      start_frame    = 1'b0;
   endtask

   task automatic wait_fd(input int n, input int lim);
      int k = 0;
      while (fd_cnt < n && k < lim) begin
         tick(1);
         k++;
      end
      check("frame_done_seen", 32'(fd_cnt >= n), 1);
   endtask

   task automatic wait_launch(input int n, input int lim);
      int k = 0;
      while (lq.size() < n && k < lim) begin
         tick(1);
         k++;
      end
      check("launch_seen", 32'(lq.size() >= n), 1);
   endtask

   task automatic check_order(input string tag, input int es[6], input int ea[6]);
      check({tag, "_count"}, 32'(lq.size()), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < lq.size()) begin
            check({tag, "_seg"}, 32'(lq[i].seg), 32'(es[i]));
            check({tag, "_aux"}, 32'(lq[i].aux), 32'(ea[i]));
            check({tag, "_txid"}, 32'(lq[i].id), 32'(i));
         end
      end
   endtask

   initial begin
      RST_N = 1'b1;
      start_frame = 1'b0;
      seg_count = '0;
      redundancy_cfg = '0;
      mode = 1'b0;
      busy = 1'b0;
      abort = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      check("rst_start_sending", 32'(start_sending), 0);
      check("rst_frame_busy", 32'(frame_busy), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_txid", 32'(txid), 0);
      check("rst_segment_num", 32'(segment_num), 0);
      check("rst_aux", 32'(aux), 0);
      tick(2);
      RST_N = 1'b1;

      // Segment-major ordering plus launch latency
      do_reset();
      start(3, 2, 1'b0);
      check("busy_after_start", 32'(frame_busy), 1);
      wait_fd(1, 400);
      check_order("m0", e_seg_m0, e_aux_m0);
      if (lq.size() > 0) check("first_launch_latency", 32'(lq[0].cyc - st_cyc), 2);
      tick(5);
      check("m0_one_frame_done", 32'(fd_cnt), 1);
      check("m0_idle_after", 32'(frame_busy), 0);

      // Copy-major ordering
      do_reset();
      start(3, 2, 1'b1);
      wait_fd(1, 400);
      check_order("m1", e_seg_m1, e_aux_m1);

      // Busy holds off the launch
      do_reset();
      busy = 1'b1;
      start(1, 1, 1'b0);
      tick(20);
      check("busy_no_launch", 32'(lq.size()), 0);
      busy = 1'b0;
      st_cyc = cyc;
      wait_launch(1, 20);
      if (lq.size() > 0) check("busy_release_latency", 32'(lq[0].cyc - st_cyc), 1);
      wait_fd(1, 100);

      // Zero segments: no launch, frame_done two cycles after start
      do_reset();
      start(0, 2, 1'b0);
      wait_fd(1, 20);
      check("zero_seg_done_latency", 32'(fd_cyc - st_cyc), 2);
      check("zero_seg_no_launch", 32'(lq.size()), 0);

      // Redundancy 0 treated as 1
      do_reset();
      start(2, 0, 1'b0);
      wait_fd(1, 200);
      check("red0_launches", 32'(lq.size()), 2);
      if (lq.size() > 1) check("red0_second_seg", 32'(lq[1].seg), 1);

      // Abort in WAIT_DONE of the second launch; start_frame with abort is ignored
      do_reset();
      start(3, 1, 1'b0);
      wait_launch(2, 200);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_frame_busy", 32'(frame_busy), 0);
      tick(30);
      check("abort_no_frame_done", 32'(fd_cnt), 0);
      check("abort_launches", 32'(lq.size()), 2);
      abort = 1'b1;
      start(1, 1, 1'b0);
      abort = 1'b0;
      tick(3);
      check("abort_beats_start", 32'(frame_busy), 0);
      start(1, 1, 1'b0);
      wait_fd(1, 100);
      if (lq.size() > 2) check("abort_next_txid", 32'(lq[2].id), 2);
      else check("abort_next_launch", 32'(lq.size()), 3);

      // Asynchronous reset in the middle of GAP
      do_reset();
      start(2, 2, 1'b0);
      wait_launch(2, 200);
      tick(7);
      check("gap_busy_pre", 32'(frame_busy), 1);
      check("gap_aux_pre", 32'(aux), 1);
      check("gap_txid_pre", 32'(txid), 1);
      #3;
      RST_N = 1'b0;
      #1;
      check("gap_rst_frame_busy", 32'(frame_busy), 0);
      check("gap_rst_txid", 32'(txid), 0);
      check("gap_rst_aux", 32'(aux), 0);
      check("gap_rst_seg", 32'(segment_num), 0);
      check("gap_rst_start_sending", 32'(start_sending), 0);
      check("gap_rst_frame_done", 32'(frame_done), 0);
      tick(2);
      RST_N = 1'b1;
      pend = 0;
      lq.delete();
      fd_cnt = 0;
      start(1, 1, 1'b0);
      wait_fd(1, 100);
      if (lq.size() > 0) check("post_rst_txid", 32'(lq[0].id), 0);

      // 256 launches wrap txid
      do_reset();
      start(256, 1, 1'b0);
      wait_fd(1, 8000);
      check("wrap_count", 32'(lq.size()), 256);
      if (lq.size() > 255) begin
         check("wrap_last_txid", 32'(lq[255].id), 255);
         check("wrap_last_seg", 32'(lq[255].seg), 255);
      end
      start(1, 1, 1'b0);
      wait_fd(2, 100);
      if (lq.size() > 256) check("wrap_txid_zero", 32'(lq[256].id), 0);
      else check("wrap_next_launch", 32'(lq.size()), 257);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
